// File: rtl/morse_sequencer_if.sv
// morse_sequencer_if: letter request, pattern mux link and LED/status lines of the Morse sequencer
interface morse_sequencer_if #(parameter int PATTERN_W = 12);
  logic                 start;
  logic [2:0]           letter_sel;
  logic [2:0]           mux_select;
  logic [PATTERN_W-1:0] pattern;
  logic                 led;
  logic                 busy;
  logic                 done;
  modport master (output start, letter_sel, pattern, input mux_select, led, busy, done);
  modport slave  (input start, letter_sel, pattern, output mux_select, led, busy, done);
endinterface

// File: rtl/morse_sequencer.sv
// morse_sequencer: latches a Morse pattern from the letter mux and shifts it MSB-first onto the LED.
// Define MORSE_EARLY_STOP_EN to end a sequence as soon as only dark bits remain.
module morse_sequencer #(
  parameter int PATTERN_W = 12,
  parameter int DIV_COUNT = 25_000_000
) (
  input logic              clk,
  input logic              resetn,
  morse_sequencer_if.slave bus
);
  localparam int DIV_W = $clog2(DIV_COUNT);
  localparam int BIT_W = $clog2(PATTERN_W + 1);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t               state_q;
  logic [2:0]           sel_q;
  logic [PATTERN_W-1:0] shreg_q;
  logic [BIT_W-1:0]     bit_q;
  logic [DIV_W-1:0]     div_q;
  logic                 tc, last;
  assign tc = div_q == DIV_W'(DIV_COUNT - 1);
`ifdef MORSE_EARLY_STOP_EN
  assign last = bit_q == BIT_W'(PATTERN_W - 1) || shreg_q[PATTERN_W-2:0] == '0;
`else
  assign last = bit_q == BIT_W'(PATTERN_W - 1);
`endif
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      sel_q   <= '0;
      shreg_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
    end else
      case (state_q)
        IDLE: if (bus.start) begin
          sel_q   <= bus.letter_sel;
          state_q <= LOAD;
        end
        LOAD: begin
          shreg_q <= bus.pattern;
          bit_q   <= '0;
          div_q   <= '0;
`ifdef MORSE_EARLY_STOP_EN
          state_q <= bus.pattern == '0 ? DONE : SHIFT;
`else
          state_q <= SHIFT;
`endif
        end
        SHIFT: if (tc) begin
          shreg_q <= shreg_q << 1;
          bit_q   <= bit_q + 1'b1;
          div_q   <= '0;
          if (last) state_q <= DONE;
        end else
          div_q <= div_q + 1'b1;
        default: state_q <= IDLE;
      endcase
  assign bus.mux_select = sel_q;
  assign bus.led        = state_q == SHIFT && shreg_q[PATTERN_W-1];
  assign bus.busy       = state_q != IDLE;
  assign bus.done       = state_q == DONE;
endmodule

// File: tb/tb_morse_sequencer.sv
// tb_morse_sequencer: directed and random letters checked against a per-cycle LED/status model.
module tb_morse_sequencer;
  localparam int W = 12;
  localparam int D = 4;
  logic clk = 0;
  logic resetn = 0;
  logic [W-1:0] rom [8];
  int n_chk = 0;
  int n_fail = 0;
  morse_sequencer_if #(.PATTERN_W(W)) bus ();
  morse_sequencer #(.PATTERN_W(W), .DIV_COUNT(D)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  assign bus.pattern = rom[bus.mux_select];
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Number of bit periods displayed for a pattern
  function automatic int nbits(input logic [W-1:0] p);
    int n = W;
`ifdef MORSE_EARLY_STOP_EN
    n = 0;
    for (int i = 0; i < W; i++) if (p[W-1-i]) n = i + 1;
`endif
    return n;
  endfunction
  task automatic run_seq(input logic [2:0] sel, input bit hold, input bit inject);
    logic [W-1:0] p;
    int nb;
    p = rom[sel];
    nb = nbits(p);
    bus.start = 1;
    bus.letter_sel = sel;
    step();
    if (!hold) bus.start = 0;
    chk("load_busy", bus.busy, 1);
    chk("load_sel", bus.mux_select, sel);
    chk("load_led", bus.led, 0);
    chk("load_done", bus.done, 0);
    step();
    for (int c = 0; c < nb * D; c++) begin
      chk("led", bus.led, p[W-1-c/D]);
      chk("busy", bus.busy, 1);
      chk("done", bus.done, 0);
      chk("sel", bus.mux_select, sel);
      if (inject && c == 5) begin bus.start = 1; bus.letter_sel = 5; end
      if (inject && c == 6) begin bus.start = 0; bus.letter_sel = sel; end
      step();
    end
    chk("done_pulse", bus.done, 1);
    chk("done_led", bus.led, 0);
    chk("done_busy", bus.busy, 1);
    step();
    chk("idle_busy", bus.busy, 0);
    chk("idle_done", bus.done, 0);
  endtask
  initial begin
    bus.start = 0;
    bus.letter_sel = 0;
    for (int i = 0; i < 8; i++) rom[i] = W'($urandom);
    rom[0] = 12'b1011_1000_0000;
    rom[4] = '0;
    rom[6] = 12'hFFF;
    #1;
    chk("rst_led", bus.led, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sel", bus.mux_select, 0);
    step();
    resetn = 1;
    step();
    chk("post_rst_busy", bus.busy, 0);
    run_seq(0, 0, 0);
    run_seq(0, 0, 1);
    run_seq(4, 0, 0);
    run_seq(3, 1, 0);
    run_seq(3, 1, 0);
    bus.start = 0;
    for (int i = 0; i < 6; i++) begin
      logic [2:0] s;
      s = 3'($urandom_range(0, 7));
      rom[s] = W'($urandom);
      run_seq(s, 0, 0);
    end
    rom[6] = 12'hFFF;
    bus.start = 1;
    bus.letter_sel = 6;
    step();
    bus.start = 0;
    repeat (10) step();
    chk("mid_busy", bus.busy, 1);
    chk("mid_led", bus.led, 1);
    #3 resetn = 0;
    #1;
    chk("arst_led", bus.led, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_sel", bus.mux_select, 0);
    step();
    step();
    resetn = 1;
    step();
    chk("rel_busy", bus.busy, 0);
    chk("rel_done", bus.done, 0);
    chk("rel_sel", bus.mux_select, 0);
    run_seq(0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
